comparator_operand_loader: RTL and testbench
============================================

Name: comparator_operand_loader

Overview:
- Upstream feeder for fourBitModifiedComparator.
- Receives operands A and B as two bit-serial lanes, MSB first, framed by a start flag.
- Assembles each frame into parallel WIDTH-bit words and holds them stable on a valid/ready interface until the consumer accepts them.
- Reports malformed frames with a one-cycle error pulse.

Parameters:
- WIDTH, 4, operand width in bits. Must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- sin_valid  input  1  serial beat present.
- sin_start  input  1  current beat is the first (MSB) bit of a frame.
- sin_a  input  1  serial bit of operand A.
- sin_b  input  1  serial bit of operand B.
- sin_ready  output  1  loader can accept a serial beat.
- A_out  output  WIDTH  assembled operand A; connects to comparator A.
- B_out  output  WIDTH  assembled operand B; connects to comparator B.
- out_valid  output  1  A_out/B_out hold a complete frame.
- out_ready  input  1  consumer accepts the held frame.
- frame_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. All state is in clk-domain registers.
- Reset values:
  - state = IDLE; shift registers = 0; bit count = 0.
  - A_out = 0, B_out = 0, out_valid = 0, frame_err = 0.
  - sin_ready = 1 (combinational from state).
- Reset mid-frame or in HOLD: the partial or held frame is discarded and no output is produced.
- Beat accepted: sin_valid && sin_ready at a rising edge.
- sin_ready = 1 in IDLE and SHIFT, 0 in HOLD. There is no input/output overlap.
- Shift rule: each lane does sh <= {sh[WIDTH-2:0], bit}, so the first bit ends up as the MSB.
- IDLE state:
  - Accepted beat with sin_start=1: shift registers = bit, count = 1, go to SHIFT.
  - If WIDTH=1, the frame completes immediately, as in the SHIFT completion rule.
  - Accepted beat with sin_start=0: beat dropped, frame_err pulses, stay in IDLE.
- SHIFT state:
  - Accepted beat with sin_start=0: shift, count++.
  - Completion: if this beat is the WIDTH-th bit, then on the same edge:
    - A_out <= {sh_a[WIDTH-2:0], sin_a}, and likewise B_out;
    - out_valid <= 1; count <= 0; go to HOLD.
  - Accepted beat with sin_start=1 (restart): discard the partial frame, shift registers = bit, count = 1, frame_err pulses, stay in SHIFT (or HOLD if WIDTH=1).
  - No beat: hold everything. Gaps in sin_valid are legal at any point.
- HOLD state:
  - out_valid = 1; A_out/B_out are stable.
  - out_ready=1 at an edge: out_valid <= 0, go to IDLE. A_out/B_out keep their last value; they are don't-care while out_valid=0, but the bench checks they retain it.
  - out_ready=0: stay in HOLD indefinitely.
- Latency: last bit accepted at edge N means out_valid is high from edge N; the earliest next frame's start is accepted at edge N+2 (edge N+1 performs the handshake).
- frame_err: registered, high for exactly one cycle per violation, 0 otherwise.
- Counter width: $clog2(WIDTH+1). The count never exceeds WIDTH.
- State encoding: 2-bit, IDLE=0, SHIFT=1, HOLD=2. Code 3 is illegal and recovers to IDLE.

Decomposition:
- Shared constants include file: state encodings (IDLE/SHIFT/HOLD) and the default WIDTH, shared with other comparator-path blocks.
- Sub-module sipo_reg (parameter WIDTH; ports clk, rst, load_first, shift_en, bit_in, q), instantiated once per lane (A, B).
- Top level holds the FSM, counter, output registers and frame_err.

Test Plan:
- Frame A=0101, B=1010, four consecutive beats with the first start=1, out_ready=1: out_valid high for one cycle after the 4th beat with A_out=0101, B_out=1010, frame_err never set.
- Backpressure: frame A=1100, B=0011 with out_ready=0 for 5 cycles while the next frame is pending on sin_valid: sin_ready=0 and outputs stable throughout; after out_ready, the next frame A=0011, B=1100 loads intact.
- Restart: 2 bits of a frame, then a new start followed by A=0011, B=0101: frame_err pulses exactly once; output = 0011/0101.
- Stray beat in IDLE (start=0, a=1, b=1): frame_err pulses, out_valid stays 0; a following frame A=0110, B=1001 is output correctly.
- Reset asserted asynchronously (between edges) after 3 bits: A_out=B_out=0 and out_valid=0 immediately; a subsequent frame A=1000, B=1000 is correct.
- Gapped beats (sin_valid low 1–3 cycles between bits), A=0111, B=1110: same result as the gapless frame; out_valid only after the 4th accepted beat.

Source files
------------

// File: rtl/comparator_operand_loader_pkg.sv
// Constants shared along the comparator operand path: the default operand width
// and the loader state encoding.
package comparator_operand_loader_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/comparator_operand_loader_sipo_reg.sv
// Serial-in parallel-out lane register. The first bit of a frame ends up as the MSB
// once WIDTH bits have been shifted in.
module sipo_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_first,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] q
);

  // Shift-and-or is used instead of a slice so that WIDTH=1 stays legal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load_first) begin
      q <= WIDTH'(bit_in);
    end else if (shift_en) begin
      q <= (q << 1) | WIDTH'(bit_in);
    end
  end

endmodule

// File: rtl/comparator_operand_loader.sv
// Assembles two MSB-first serial operand lanes into parallel words and holds them
// on a valid/ready interface for the comparator; flags malformed frames.
module comparator_operand_loader
  import comparator_operand_loader_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin_valid,
  input  logic             sin_start,
  input  logic             sin_a,
  input  logic             sin_b,
  output logic             sin_ready,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             beat;
  logic             load_first;
  logic             shift_en;
  logic             complete;
  logic             err_nxt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] word_a;
  logic [WIDTH-1:0] word_b;

  sipo_reg #(.WIDTH(WIDTH)) u_lane_a (
    .clk        (clk),
    .rst        (rst),
    .load_first (load_first),
    .shift_en   (shift_en),
    .bit_in     (sin_a),
    .q          (sh_a)
  );

  sipo_reg #(.WIDTH(WIDTH)) u_lane_b (
    .clk        (clk),
    .rst        (rst),
    .load_first (load_first),
    .shift_en   (shift_en),
    .bit_in     (sin_b),
    .q          (sh_b)
  );

  assign sin_ready = (state == ST_IDLE) || (state == ST_SHIFT);
  assign beat      = sin_valid && sin_ready;

  // Word as it will look after this beat; equals the lone bit on a frame start when WIDTH=1.
  assign word_a = (sh_a << 1) | WIDTH'(sin_a);
  assign word_b = (sh_b << 1) | WIDTH'(sin_b);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    load_first = 1'b0;
    shift_en   = 1'b0;
    complete   = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (beat) begin
          if (sin_start) begin
            load_first = 1'b1;
            cnt_nxt    = CW'(1);
            state_nxt  = ST_SHIFT;
            if (WIDTH == 1) complete = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (beat) begin
          if (sin_start) begin
            load_first = 1'b1;
            err_nxt    = 1'b1;
            cnt_nxt    = CW'(1);
            if (WIDTH == 1) complete = 1'b1;
          end else begin
            shift_en = 1'b1;
            cnt_nxt  = cnt + CW'(1);
            if (cnt == LAST) complete = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (complete) begin
      state_nxt = ST_HOLD;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      A_out     <= '0;
      B_out     <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      frame_err <= err_nxt;
      out_valid <= (state_nxt == ST_HOLD);
      if (complete) begin
        A_out <= word_a;
        B_out <= word_b;
      end
    end
  end

endmodule

// File: tb/tb_comparator_operand_loader.sv
// Bench for comparator_operand_loader: directed vector table, hand-written corner
// sequences and random traffic, all checked against a frame-level reference model.
module tb_comparator_operand_loader;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         sin_valid, sin_start, sin_a, sin_b, out_ready;
  logic         sin_ready, out_valid, frame_err;
  logic [W-1:0] A_out, B_out;

  comparator_operand_loader #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin_valid (sin_valid),
    .sin_start (sin_start),
    .sin_a     (sin_a),
    .sin_b     (sin_b),
    .sin_ready (sin_ready),
    .A_out     (A_out),
    .B_out     (B_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a frame is a list of collected bits; a finished frame is held
  // until the consumer takes it.
  bit m_held, m_inframe;
  int m_nbits, m_acc_a, m_acc_b, m_out_a, m_out_b;
  bit m_err;

  task automatic model_reset();
    m_held = 0; m_inframe = 0; m_nbits = 0;
    m_acc_a = 0; m_acc_b = 0; m_out_a = 0; m_out_b = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit v, s, a, b, r);
    m_err = 0;
    if (m_held) begin
      if (r) m_held = 0;
    end else if (v) begin
      if (s) begin
        if (m_inframe) m_err = 1;
        m_inframe = 1; m_nbits = 1; m_acc_a = a; m_acc_b = b;
      end else if (!m_inframe) begin
        m_err = 1;
      end else begin
        m_acc_a = (m_acc_a * 2 + a) % (1 << W);
        m_acc_b = (m_acc_b * 2 + b) % (1 << W);
        m_nbits++;
      end
      if (m_inframe && m_nbits == W) begin
        m_out_a = m_acc_a; m_out_b = m_acc_b;
        m_held = 1; m_inframe = 0; m_nbits = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1: drive, check ready, clock, check outputs against the model.
  task automatic step(input bit v, s, a, b, r);
    sin_valid = v; sin_start = s; sin_a = a; sin_b = b; out_ready = r;
    #1;
    chk("sin_ready", 32'(sin_ready), 32'(!m_held));
    model_edge(v, s, a, b, r);
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_held));
    chk("A_out", 32'(A_out), 32'(m_out_a));
    chk("B_out", 32'(B_out), 32'(m_out_b));
    chk("frame_err", 32'(frame_err), 32'(m_err));
  endtask

  task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b, input int max_gap);
    logic [W-1:0] ta, tb;
    ta = a; tb = b;
    for (int i = W - 1; i >= 0; i--) begin
      step(1, i == W - 1, ta[i], tb[i], 0);
      if (i > 0) begin
        chk("gap_no_valid", 32'(out_valid), 32'd0);
        if (max_gap > 0) begin
          int g;
          g = int'($urandom_range(1, max_gap));
          for (int k = 0; k < g; k++) step(0, 0, 0, 0, 0);
        end
      end
    end
  endtask

  typedef struct {
    bit v, s, a, b, r;
    bit exp_ready, exp_valid, exp_err;
    logic [W-1:0] exp_a, exp_b;
  } vec_t;

  vec_t vt[20];

  initial begin
    rst = 1'b1; sin_valid = 0; sin_start = 0; sin_a = 0; sin_b = 0; out_ready = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_A", 32'(A_out), 32'd0);
    chk("rst_B", 32'(B_out), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_ready", 32'(sin_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    //        v  s  a  b  r   rdy val err  A      B
    vt[0]  = '{1, 1, 0, 1, 1,  1,  0,  0, 4'h0, 4'h0};
    vt[1]  = '{1, 0, 1, 0, 1,  1,  0,  0, 4'h0, 4'h0};
    vt[2]  = '{1, 0, 0, 1, 1,  1,  0,  0, 4'h0, 4'h0};
    vt[3]  = '{1, 0, 1, 0, 1,  1,  1,  0, 4'h5, 4'hA};
    vt[4]  = '{0, 0, 0, 0, 1,  0,  0,  0, 4'h5, 4'hA};
    vt[5]  = '{1, 0, 1, 1, 0,  1,  0,  1, 4'h5, 4'hA};
    vt[6]  = '{0, 0, 0, 0, 0,  1,  0,  0, 4'h5, 4'hA};
    vt[7]  = '{1, 1, 0, 1, 0,  1,  0,  0, 4'h5, 4'hA};
    vt[8]  = '{1, 0, 1, 0, 0,  1,  0,  0, 4'h5, 4'hA};
    vt[9]  = '{1, 0, 1, 0, 0,  1,  0,  0, 4'h5, 4'hA};
    vt[10] = '{1, 0, 0, 1, 0,  1,  1,  0, 4'h6, 4'h9};
    vt[11] = '{0, 0, 0, 0, 0,  0,  1,  0, 4'h6, 4'h9};
    vt[12] = '{0, 0, 0, 0, 1,  0,  0,  0, 4'h6, 4'h9};
    vt[13] = '{1, 1, 1, 1, 0,  1,  0,  0, 4'h6, 4'h9};
    vt[14] = '{1, 0, 1, 1, 0,  1,  0,  0, 4'h6, 4'h9};
    vt[15] = '{1, 1, 0, 0, 0,  1,  0,  1, 4'h6, 4'h9};
    vt[16] = '{1, 0, 0, 1, 0,  1,  0,  0, 4'h6, 4'h9};
    vt[17] = '{1, 0, 1, 0, 0,  1,  0,  0, 4'h6, 4'h9};
    vt[18] = '{1, 0, 1, 1, 0,  1,  1,  0, 4'h3, 4'h5};
    vt[19] = '{0, 0, 0, 0, 1,  0,  0,  0, 4'h3, 4'h5};

    for (int i = 0; i < 20; i++) begin
      chk("tbl_ready", 32'(sin_ready), 32'(vt[i].exp_ready));
      step(vt[i].v, vt[i].s, vt[i].a, vt[i].b, vt[i].r);
      chk("tbl_valid", 32'(out_valid), 32'(vt[i].exp_valid));
      chk("tbl_err", 32'(frame_err), 32'(vt[i].exp_err));
      chk("tbl_A", 32'(A_out), 32'(vt[i].exp_a));
      chk("tbl_B", 32'(B_out), 32'(vt[i].exp_b));
    end

    // Backpressure with the next frame's first beat already pending.
    send_frame(4'hC, 4'h3, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 1, 0);
      chk("bp_ready", 32'(sin_ready), 32'd0);
      chk("bp_A", 32'(A_out), 32'hC);
      chk("bp_B", 32'(B_out), 32'h3);
    end
    step(1, 1, 0, 1, 1);
    chk("bp_release", 32'(out_valid), 32'd0);
    send_frame(4'h3, 4'hC, 0);
    chk("bp_next_A", 32'(A_out), 32'h3);
    chk("bp_next_B", 32'(B_out), 32'hC);
    step(0, 0, 0, 0, 1);

    // Asynchronous reset between edges after three bits.
    step(1, 1, 1, 1, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    #3 rst = 1'b1;
    #1;
    chk("arst_A", 32'(A_out), 32'd0);
    chk("arst_B", 32'(B_out), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame(4'h8, 4'h8, 0);
    chk("arst_next_A", 32'(A_out), 32'h8);
    chk("arst_next_B", 32'(B_out), 32'h8);
    step(0, 0, 0, 0, 1);

    // Gapped beats.
    send_frame(4'h7, 4'hE, 3);
    chk("gap_valid", 32'(out_valid), 32'd1);
    chk("gap_A", 32'(A_out), 32'h7);
    chk("gap_B", 32'(B_out), 32'hE);
    step(0, 0, 0, 0, 1);

    // Random traffic, including stray beats, restarts and stalls.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, ($urandom % 5) == 0, $urandom % 2, $urandom % 2,
           ($urandom % 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
